// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared 7-segment codes and digit-slot type for the parking monitor
package parking_pkg;

    // Active-low segments, gfedcba order (bit 6 = g)
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        SLOT_LIV_UNI = 2'd0,
        SLOT_LIV_DEZ = 2'd1,
        SLOT_OCU_UNI = 2'd2,
        SLOT_OCU_DEZ = 2'd3
    } slot_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/debounce_vaga.sv
// rtl/debounce_vaga.sv - two-flop synchronizer plus consecutive-cycle debounce for one sensor
module debounce_vaga #(
    parameter int DEB_CYC = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filtered
);

    localparam int CW = $clog2(DEB_CYC);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            cnt      <= '0;
            filtered <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Any cycle agreeing with the filtered value restarts the interval
            if (s2 != filtered) begin
                if (cnt == CW'(DEB_CYC - 1)) begin
                    filtered <= s2;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/parking_monitor.sv
// rtl/parking_monitor.sv - occupancy counter with multiplexed 4-digit display and full-lot blink
module parking_monitor
    import parking_pkg::*;
#(
    parameter int N_VAGAS     = 8,
    parameter int DEB_CYC     = 500000,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 100
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [N_VAGAS-1:0] Vagas,
    output logic [6:0]         Display,
    output logic [3:0]         DigitoAceso,
    output logic               Cheio,
    output logic               Vazio
);

    localparam int CW = $clog2(N_VAGAS + 1);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);

    logic [N_VAGAS-1:0] filt;
    logic [CW-1:0]      pop;
    logic [CW-1:0]      ocupadas;
    logic [CW-1:0]      livres;
    logic [RW-1:0]      ref_cnt;
    logic [BW-1:0]      blink_cnt;
    logic               phase;
    logic               tick;
    slot_t              slot;
    logic [6:0]         ocu7;
    logic [6:0]         liv7;
    logic [3:0]         digit;

    for (genvar i = 0; i < N_VAGAS; i++) begin : g_vaga
        debounce_vaga #(
            .DEB_CYC (DEB_CYC)
        ) u_deb (
            .clock    (Clock),
            .reset    (Reset),
            .raw      (Vagas[i]),
            .filtered (filt[i])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_VAGAS; i++) begin
            pop = pop + CW'(filt[i]);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ocupadas <= '0;
            livres   <= CW'(N_VAGAS);
            Cheio    <= 1'b0;
            Vazio    <= 1'b1;
        end else begin
            ocupadas <= pop;
            livres   <= CW'(N_VAGAS) - pop;
            Cheio    <= (pop == CW'(N_VAGAS));
            Vazio    <= (pop == '0);
        end
    end

    assign tick = (ref_cnt == RW'(REFRESH_DIV - 1));

    always_comb begin
        ocu7 = 7'(ocupadas);
        liv7 = 7'(livres);
        case (slot)
            SLOT_OCU_DEZ: digit = 4'(ocu7 / 7'd10);
            SLOT_OCU_UNI: digit = 4'(ocu7 % 7'd10);
            SLOT_LIV_DEZ: digit = 4'(liv7 / 7'd10);
            default:      digit = 4'(liv7 % 7'd10);
        endcase
    end

    // slot holds the digit to be latched at the next refresh tick
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ref_cnt     <= '0;
            slot        <= SLOT_OCU_DEZ;
            Display     <= SEG_BLANK;
            DigitoAceso <= 4'b1111;
        end else if (tick) begin
            ref_cnt     <= '0;
            slot        <= slot_t'(slot - 2'd1);
            DigitoAceso <= ~(4'b0001 << slot);
            if (Cheio && phase && !slot[1]) begin
                Display <= SEG_BLANK;
            end else begin
                Display <= seg7(digit);
            end
        end else begin
            ref_cnt <= ref_cnt + RW'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (!Cheio) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick && slot == SLOT_LIV_UNI) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BW'(1);
            end
        end
    end

endmodule
